// File: rtl/mod_inv_if.sv
// ----------------------------------------------------------------------------
// mod_inv_if: enable/done handshake bundle for the modular-inverse stage.
// Uses the same level-style handshake as the ModMul/ModAdd stages, so an
// upstream done can drive enable directly.
//   enable : level request, sampled while the inverter is idle
//   a      : operand (field element), latched when the operation starts
//   r      : result a^-1 mod p, 0 on error
//   done   : level, high while r/err are valid
//   err    : high with done when the operand was 0 or >= p
// Modports: master drives enable/a, slave (the inverter) drives r/done/err.
// ----------------------------------------------------------------------------
interface mod_inv_if #(
  parameter int unsigned width = 32
);
  logic             enable;
  logic [width-1:0] a;
  logic [width-1:0] r;
  logic             done;
  logic             err;

  modport master (
    output enable,
    output a,
    input  r,
    input  done,
    input  err
  );

  modport slave (
    input  enable,
    input  a,
    output r,
    output done,
    output err
  );
endinterface

// File: rtl/mod_inv.sv
// ----------------------------------------------------------------------------
// mod_inv: iterative modular inverse r = a^-1 mod p using the binary extended
// Euclidean algorithm, one step per clock.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; aborts any operation and clears state
//   bus   : mod_inv_if.slave (enable, a in; r, done, err out)
// Flow: IDLE --enable--> RUN (or straight to DONE on an invalid operand)
//       --> DONE (done raised one cycle after entry) --enable low--> IDLE.
// Invariants during RUN: u = a*x1 and v = a*x2 (mod p), u,v > 0, x1,x2 < p.
// ----------------------------------------------------------------------------
module mod_inv #(
  parameter int unsigned p     = 37,
  parameter int unsigned width = 32
) (
  input  logic       clk,
  input  logic       reset,
  mod_inv_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [width-1:0] p_w   = width'(p);
  localparam logic [width:0]   p_ext = (width+1)'(p);

  state_t           state;
  logic [width-1:0] u;
  logic [width-1:0] v;
  logic [width-1:0] x1;
  logic [width-1:0] x2;
  // Invalid-operand flag; copied to err on the same edge that raises done.
  logic             bad;

  // x/2 mod p. For odd x, x+p is even and needs one extra bit before halving.
  function automatic logic [width-1:0] half_mod(input logic [width-1:0] x);
    logic [width:0] s;
    s = x[0] ? ({1'b0, x} + p_ext) : {1'b0, x};
    return width'(s >> 1);
  endfunction

  // (x - y) mod p for x, y < p; the wrap case adds p first in width+1 bits.
  function automatic logic [width-1:0] sub_mod(input logic [width-1:0] x,
                                               input logic [width-1:0] y);
    logic [width:0] s;
    if (x >= y) s = {1'b0, x} - {1'b0, y};
    else        s = {1'b0, x} + p_ext - {1'b0, y};
    return width'(s);
  endfunction

  // NOTE: all state, including the u/v/x1/x2 datapath, is reset so that an
  // abort leaves no stale values behind; sequential state uses non-blocking
  // assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      u        <= '0;
      v        <= '0;
      x1       <= '0;
      x2       <= '0;
      bad      <= 1'b0;
      bus.r    <= '0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            if (bus.a == '0 || bus.a >= p_w) begin
              bad   <= 1'b1;
              bus.r <= '0;
              state <= DONE;
            end else begin
              u     <= bus.a;
              v     <= p_w;
              x1    <= width'(1);
              x2    <= '0;
              bad   <= 1'b0;
              state <= RUN;
            end
          end
        end

        RUN: begin
          // Priority order matters: termination tests before reductions.
          if (u == width'(1)) begin
            bus.r <= x1;
            state <= DONE;
          end else if (v == width'(1)) begin
            bus.r <= x2;
            state <= DONE;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= half_mod(x1);
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= half_mod(x2);
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= sub_mod(x1, x2);
          end else begin
            v  <= v - u;
            x2 <= sub_mod(x2, x1);
          end
        end

        DONE: begin
          // done is raised on the first DONE cycle regardless of enable, so a
          // completed result is always visible for at least one cycle.
          if (!bus.done) begin
            bus.done <= 1'b1;
            bus.err  <= bad;
          end else if (!bus.enable) begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
